// File: rtl/gate_update_mc.sv
`default_nettype none
// ============================================================================
// Module   : gate_update_mc
// Purpose  : Multi-channel Hodgkin-Huxley gating-variable integrator. Holds
//            NCH gate states (unsigned, FRAC = GW-2 fractional bits). On each
//            start pulse it sweeps every channel once: looks up alpha/beta
//            for that channel's snapshotted membrane voltage in a run-time
//            loadable rate table and applies one Euler step
//              x += dt * (alpha*(1-x) - beta*x), saturated to [0, ONE].
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   start      in   begin one sweep (accepted in IDLE only)
//   clear      in   synchronous: all gates <- N_INIT, abort sweep
//   v_bus      in   packed channel voltages, channel k at [k*VW +: VW]
//   dt         in   Euler time step (DTFRAC = 12 fractional bits, ms)
//   tbl_we     in   rate-table write strobe (honoured in IDLE only)
//   tbl_addr   in   rate-table write address
//   tbl_alpha  in   alpha entry (RFRAC = 8 fractional bits, 1/ms)
//   tbl_beta   in   beta entry  (RFRAC = 8 fractional bits, 1/ms)
//   busy       out  sweep in progress
//   done       out  1-cycle pulse at end of sweep
//   out_valid  out  1-cycle pulse: out_ch/out_n carry a fresh update
//   out_ch     out  channel index of out_n
//   out_n      out  updated gate value
//   sat        out  sticky: an update was clipped; cleared by accepted start
//   tbl_err    out  1-cycle pulse: table write dropped because busy
//   n_all      out  packed registered gate states
// ============================================================================
module gate_update_mc #(
    parameter int NCH    = 4,
    parameter int VW     = 16,
    parameter int GW     = 16,
    parameter int RW     = 16,
    parameter int DTW    = 16,
    parameter int LUT_AW = 7,
    parameter int VMIN   = -100,
    parameter int N_INIT = 33
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    start,
    input  logic                                    clear,
    input  logic [NCH*VW-1:0]                       v_bus,
    input  logic [DTW-1:0]                          dt,
    input  logic                                    tbl_we,
    input  logic [LUT_AW-1:0]                       tbl_addr,
    input  logic [RW-1:0]                           tbl_alpha,
    input  logic [RW-1:0]                           tbl_beta,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    out_valid,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] out_ch,
    output logic [GW-1:0]                           out_n,
    output logic                                    sat,
    output logic                                    tbl_err,
    output logic [NCH*GW-1:0]                       n_all
);

    localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int FRAC   = GW - 2;
    localparam int RFRAC  = 8;
    localparam int DTFRAC = 12;
    localparam int SHIFT  = RFRAC + DTFRAC;
    localparam int DW     = GW + RW + 2;      // signed rate-difference width
    localparam int PW     = DW + DTW + 1;     // signed product/accumulate width
    localparam int DEPTH  = 2 ** LUT_AW;

    localparam logic [GW-1:0]        ONE_G  = GW'(2 ** FRAC);
    localparam logic signed [PW-1:0] ONE_P  = PW'(2 ** FRAC);
    localparam logic [GW-1:0]        INIT_G = GW'(N_INIT);
    localparam logic signed [VW-1:0] VLO    = VW'(VMIN);
    localparam logic signed [VW-1:0] VHI    = VW'(VMIN + DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_MUL    = 3'd2,
        S_UPD    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Rate table: plain RAM, deliberately not reset so contents survive reset.
    logic [RW-1:0] alpha_mem [DEPTH];
    logic [RW-1:0] beta_mem  [DEPTH];

    state_t             state_q;
    logic [CHW-1:0]     ch_q;
    logic [NCH*VW-1:0]  v_snap_q;
    logic [DTW-1:0]     dt_q;
    logic [RW-1:0]      alpha_q;
    logic [RW-1:0]      beta_q;
    logic [GW-1:0]      gate_q [NCH];
    logic               busy_q;
    logic               done_q;
    logic               out_valid_q;
    logic [CHW-1:0]     out_ch_q;
    logic [GW-1:0]      out_n_q;
    logic               sat_q;
    logic               tbl_err_q;

    // Datapath for the channel currently addressed by ch_q
    logic signed [VW-1:0] v_cur;
    logic [LUT_AW-1:0]    idx;
    logic [GW-1:0]        x_cur;
    logic [GW+RW-1:0]     prod_a;
    logic [GW+RW-1:0]     prod_b;
    logic signed [DW-1:0] d_rate;
    logic signed [PW-1:0] d_ext;
    logic signed [PW-1:0] dt_ext;
    logic signed [PW-1:0] prod_dt;
    logic signed [PW-1:0] delta;
    logic signed [PW-1:0] sum;
    logic [GW-1:0]        gate_d;
    logic                 clip_d;

    always_comb begin
        v_cur = v_snap_q[int'(ch_q) * VW +: VW];

        // Voltages outside the table span use the end entries.
        if (v_cur < VLO) begin
            idx = '0;
        end else if (v_cur > VHI) begin
            idx = '1;
        end else begin
            idx = LUT_AW'(v_cur - VLO);
        end

        x_cur  = gate_q[ch_q];
        // x never exceeds ONE, so ONE - x cannot underflow.
        prod_a = alpha_q * (ONE_G - x_cur);
        prod_b = beta_q * x_cur;
        d_rate = $signed({2'b00, prod_a}) - $signed({2'b00, prod_b});

        d_ext   = PW'(d_rate);
        dt_ext  = $signed(PW'(dt_q));
        prod_dt = d_ext * dt_ext;
        // Arithmetic shift gives floor rounding for negative steps.
        delta   = prod_dt >>> SHIFT;
        sum     = delta + $signed(PW'(x_cur));

        if (sum[PW-1]) begin
            gate_d = '0;
            clip_d = 1'b1;
        end else if (sum > ONE_P) begin
            gate_d = ONE_G;
            clip_d = 1'b1;
        end else begin
            gate_d = sum[GW-1:0];
            clip_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (tbl_we && (state_q == S_IDLE)) begin
            alpha_mem[tbl_addr] <= tbl_alpha;
            beta_mem[tbl_addr]  <= tbl_beta;
        end
    end

    // Sweep controller. The gate update is registered at the end of MUL so
    // that out_valid and the new gate value appear together in the UPD cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            v_snap_q    <= '0;
            dt_q        <= '0;
            alpha_q     <= '0;
            beta_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_n_q     <= '0;
            sat_q       <= 1'b0;
            tbl_err_q   <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                gate_q[i] <= INIT_G;
            end
        end else begin
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            tbl_err_q   <= tbl_we && (state_q != S_IDLE);

            if (clear) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                for (int i = 0; i < NCH; i++) begin
                    gate_q[i] <= INIT_G;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q  <= S_LOOKUP;
                            busy_q   <= 1'b1;
                            sat_q    <= 1'b0;
                            ch_q     <= '0;
                            v_snap_q <= v_bus;
                            dt_q     <= dt;
                        end
                    end
                    S_LOOKUP: begin
                        alpha_q <= alpha_mem[idx];
                        beta_q  <= beta_mem[idx];
                        state_q <= S_MUL;
                    end
                    S_MUL: begin
                        gate_q[ch_q] <= gate_d;
                        out_valid_q  <= 1'b1;
                        out_ch_q     <= ch_q;
                        out_n_q      <= gate_d;
                        if (clip_d) begin
                            sat_q <= 1'b1;
                        end
                        state_q <= S_UPD;
                    end
                    S_UPD: begin
                        if (ch_q == CHW'(NCH - 1)) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            ch_q    <= ch_q + 1'b1;
                            state_q <= S_LOOKUP;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    generate
        for (genvar g = 0; g < NCH; g++) begin : g_nall
            assign n_all[g*GW +: GW] = gate_q[g];
        end
    endgenerate

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_n     = out_n_q;
    assign sat       = sat_q;
    assign tbl_err   = tbl_err_q;

endmodule
`default_nettype wire
